// File: rtl/nn_result_scorer.sv
// Serial argmax scorer: finds the winning class of each score stream, checks it against the label,
// and keeps saturating sample/correct counters. Optional runner-up margin via NN_SCORER_MARGIN_EN.
module nn_result_scorer #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16,
    parameter int CLASS_W     = 4,
    parameter int CNT_W       = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               score_valid,
    input  logic [DATA_W-1:0]  score_data,
    input  logic               score_last,
    input  logic [CLASS_W-1:0] label,
    output logic               score_ready,
    output logic               class_valid,
    output logic [CLASS_W-1:0] class_out,
    output logic               correct,
    output logic [CNT_W-1:0]   sample_count,
    output logic [CNT_W-1:0]   correct_count,
    output logic               protocol_err,
    output logic [DATA_W:0]    margin
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT} state_t;

    localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    state_t                     r_state;
    state_t                     w_next_state;
    logic signed [DATA_W-1:0]   r_max;
    logic [CLASS_W-1:0]         r_max_idx;
    logic [CLASS_W-1:0]         r_idx;
    logic [CLASS_W-1:0]         r_label;
    logic [CLASS_W-1:0]         r_class_out;
    logic                       r_correct;
    logic [CNT_W-1:0]           r_sample_count;
    logic [CNT_W-1:0]           r_correct_count;
    logic                       r_protocol_err;

    logic                       w_accept;
    logic signed [DATA_W-1:0]   w_score;
    logic                       w_gt;
    logic                       w_first_beat;
    logic                       w_scan_beat;
    logic                       w_final_beat;
    logic                       w_frame_err;
    logic signed [DATA_W-1:0]   w_scan_max;
    logic [CLASS_W-1:0]         w_scan_idx;

    assign w_accept     = score_valid && score_ready;
    assign w_score      = $signed(score_data);
    assign w_gt         = w_score > r_max;
    assign w_first_beat = (r_state == S_IDLE) && w_accept && !score_last;
    assign w_scan_beat  = (r_state == S_SCAN) && w_accept;
    assign w_final_beat = w_scan_beat && (r_idx == LAST_IDX);
    // Strict compare keeps the lower index on ties.
    assign w_scan_max   = w_gt ? w_score : r_max;
    assign w_scan_idx   = w_gt ? r_idx : r_max_idx;
    assign w_frame_err  = ((r_state == S_IDLE) && w_accept && score_last)
                       || (w_scan_beat && (score_last != (r_idx == LAST_IDX)));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: default assignment first so no path through the case leaves a latch behind.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_first_beat) w_next_state = S_SCAN;
            S_SCAN: begin
                if (w_final_beat)                     w_next_state = S_REPORT;
                else if (w_scan_beat && score_last)   w_next_state = S_IDLE;
            end
            S_REPORT: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        score_ready = (r_state != S_REPORT);
        class_valid = (r_state == S_REPORT);
        correct     = (r_state == S_REPORT) && r_correct;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max           <= '0;
            r_max_idx       <= '0;
            r_idx           <= '0;
            r_label         <= '0;
            r_class_out     <= '0;
            r_correct       <= 1'b0;
            r_sample_count  <= '0;
            r_correct_count <= '0;
            r_protocol_err  <= 1'b0;
        end else begin
            if (w_first_beat) begin
                r_max     <= w_score;
                r_max_idx <= '0;
                r_label   <= label;
                r_idx     <= CLASS_W'(1);
            end else if (w_scan_beat) begin
                r_max     <= w_scan_max;
                r_max_idx <= w_scan_idx;
                r_idx     <= r_idx + 1'b1;
            end

            // Result registered on the final beat so it is on the outputs during the report pulse.
            if (w_final_beat) begin
                r_class_out <= w_scan_idx;
                r_correct   <= (w_scan_idx == r_label);
            end

            if (clear)            r_protocol_err <= 1'b0;
            else if (w_frame_err) r_protocol_err <= 1'b1;

            if (clear) begin
                r_sample_count  <= '0;
                r_correct_count <= '0;
            end else if (r_state == S_REPORT) begin
                if (r_sample_count != CNT_MAX)
                    r_sample_count <= r_sample_count + 1'b1;
                if (r_correct && (r_correct_count != CNT_MAX))
                    r_correct_count <= r_correct_count + 1'b1;
            end
        end
    end

    assign class_out     = r_class_out;
    assign sample_count  = r_sample_count;
    assign correct_count = r_correct_count;
    assign protocol_err  = r_protocol_err;

`ifdef NN_SCORER_MARGIN_EN
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] r_second;
    logic [DATA_W:0]          r_margin;
    logic signed [DATA_W-1:0] w_scan_second;

    // A displaced max becomes the runner-up; otherwise a beat can only raise the runner-up.
    assign w_scan_second = w_gt ? r_max : ((w_score > r_second) ? w_score : r_second);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_second <= MOST_NEG;
            r_margin <= '0;
        end else begin
            if (w_first_beat)     r_second <= MOST_NEG;
            else if (w_scan_beat) r_second <= w_scan_second;

            if (w_final_beat)
                r_margin <= {w_scan_max[DATA_W-1], w_scan_max}
                          - {w_scan_second[DATA_W-1], w_scan_second};
        end
    end

    assign margin = r_margin;
`else
    assign margin = '0;
`endif

endmodule

// File: tb/tb_nn_result_scorer.sv
// Self-checking bench for nn_result_scorer: directed cases plus randomized samples checked
// against an argmax/label/counter reference model.
module tb_nn_result_scorer;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 16;
    localparam int CLASS_W     = 4;
    localparam int CNT_W       = 10;
    localparam int CNT_SAT     = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic               score_valid;
    logic [DATA_W-1:0]  score_data;
    logic               score_last;
    logic [CLASS_W-1:0] label;
    logic               score_ready;
    logic               class_valid;
    logic [CLASS_W-1:0] class_out;
    logic               correct;
    logic [CNT_W-1:0]   sample_count;
    logic [CNT_W-1:0]   correct_count;
    logic               protocol_err;
    logic [DATA_W:0]    margin;

    nn_result_scorer #(
        .NUM_CLASSES(NUM_CLASSES), .DATA_W(DATA_W), .CLASS_W(CLASS_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .score_valid(score_valid), .score_data(score_data), .score_last(score_last),
        .label(label), .score_ready(score_ready), .class_valid(class_valid),
        .class_out(class_out), .correct(correct), .sample_count(sample_count),
        .correct_count(correct_count), .protocol_err(protocol_err), .margin(margin)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int m_samples = 0;
    int m_correct = 0;
    int m_class   = 0;
    logic signed [DATA_W-1:0] s_sc [NUM_CLASSES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: first index holding the maximum score.
    function automatic int ref_argmax();
        int best = 0;
        for (int i = 1; i < NUM_CLASSES; i++)
            if (int'(s_sc[i]) > int'(s_sc[best])) best = i;
        return best;
    endfunction

    // Reference: winner minus the largest of all remaining scores (ties give 0).
    function automatic int ref_margin(input int win);
        int sec = -(1 << 30);
        for (int j = 0; j < NUM_CLASSES; j++)
            if (j != win && int'(s_sc[j]) > sec) sec = int'(s_sc[j]);
        return int'(s_sc[win]) - sec;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beats(input int nb, input int last_at, input int lab, input bit bubbles);
        for (int i = 0; i < nb; i++) begin
            if (bubbles)
                for (int k = 0; k < 3 && $urandom_range(0, 3) == 0; k++) begin
                    score_valid = 1'b0;
                    tick();
                end
            score_valid = 1'b1;
            score_data  = s_sc[i];
            score_last  = (i == last_at);
            label       = (i == 0) ? CLASS_W'(lab) : CLASS_W'($urandom);
            tick();
        end
        score_valid = 1'b0;
        score_last  = 1'b0;
    endtask

    // Sends one well-formed sample and checks the report pulse and the counters after it.
    task automatic run_sample(input string tag, input int lab, input bit bubbles, input bit do_clear);
        int  win;
        bit  ok;
        win = ref_argmax();
        ok  = (lab == win);
        drive_beats(NUM_CLASSES, NUM_CLASSES - 1, lab, bubbles);
        check({tag, ".class_valid"}, 32'(class_valid), 32'd1);
        check({tag, ".ready_low"},   32'(score_ready), 32'd0);
        check({tag, ".class_out"},   32'(class_out),   32'(win));
        check({tag, ".correct"},     32'(correct),     32'(ok));
`ifdef NN_SCORER_MARGIN_EN
        check({tag, ".margin"},      32'(margin),      32'(ref_margin(win)));
`else
        check({tag, ".margin"},      32'(margin),      32'd0);
`endif
        clear = do_clear;
        tick();
        clear = 1'b0;
        if (do_clear) begin
            m_samples = 0;
            m_correct = 0;
        end else begin
            if (m_samples < CNT_SAT) m_samples++;
            if (ok && m_correct < CNT_SAT) m_correct++;
        end
        m_class = win;
        check({tag, ".pulse_end"},     32'(class_valid),   32'd0);
        check({tag, ".sample_count"},  32'(sample_count),  32'(m_samples));
        check({tag, ".correct_count"}, 32'(correct_count), 32'(m_correct));
        check({tag, ".class_held"},    32'(class_out),     32'(m_class));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".ready"},       32'(score_ready),   32'd1);
        check({tag, ".class_valid"}, 32'(class_valid),   32'd0);
        check({tag, ".class_out"},   32'(class_out),     32'd0);
        check({tag, ".correct"},     32'(correct),       32'd0);
        check({tag, ".samples"},     32'(sample_count),  32'd0);
        check({tag, ".corrects"},    32'(correct_count), 32'd0);
        check({tag, ".err"},         32'(protocol_err),  32'd0);
        check({tag, ".margin"},      32'(margin),        32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lab;
        rst = 1'b1; clear = 1'b0; score_valid = 1'b0; score_data = '0; score_last = 1'b0; label = '0;
        tick(); tick();
        rst = 1'b0;
        check_reset_state("reset");

        // Directed: tie at 12 resolves to the lower index.
        s_sc = '{16'sd3, -16'sd7, 16'sd12, 16'sd5, 16'sd12, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd1};
        run_sample("tie", 2, 1'b0, 1'b0);

        // Directed: all most-negative except the last class.
        for (int i = 0; i < NUM_CLASSES; i++) s_sc[i] = 16'sh8000;
        s_sc[9] = -16'sd1;
        run_sample("neg", 4, 1'b0, 1'b0);

        // Early last on beat 4: error, no result, counters unchanged.
        drive_beats(5, 4, 1, 1'b0);
        check("early.class_valid", 32'(class_valid), 32'd0);
        check("early.err",         32'(protocol_err), 32'd1);
        tick();
        check("early.no_pulse",    32'(class_valid), 32'd0);
        check("early.samples",     32'(sample_count), 32'(m_samples));
        check("early.corrects",    32'(correct_count), 32'(m_correct));

        // Next well-formed sample still reports; error stays sticky.
        for (int i = 0; i < NUM_CLASSES; i++) s_sc[i] = DATA_W'(i * 3);
        run_sample("after_err", 9, 1'b0, 1'b0);
        check("after_err.err_sticky", 32'(protocol_err), 32'd1);

        // Clear during the report cycle wins over the increment and clears the error.
        for (int i = 0; i < NUM_CLASSES; i++) s_sc[i] = DATA_W'($urandom);
        run_sample("clear", 0, 1'b0, 1'b1);
        check("clear.err", 32'(protocol_err), 32'd0);

        // Randomized samples with bubbles, ties and out-of-range labels.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NUM_CLASSES; i++)
                s_sc[i] = (n % 3 == 0) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
            lab = (n % 4 == 0) ? ref_argmax() : int'($urandom_range(0, 15));
            run_sample($sformatf("rand%0d", n), lab, 1'b1, 1'b0);
        end

        // Saturation: 1030 correct samples after a clear.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_samples = 0;
        m_correct = 0;
        for (int n = 0; n < 1030; n++) begin
            lab = n % NUM_CLASSES;
            for (int i = 0; i < NUM_CLASSES; i++) s_sc[i] = DATA_W'(-i);
            s_sc[lab] = 16'sd100;
            drive_beats(NUM_CLASSES, NUM_CLASSES - 1, lab, 1'b0);
            tick();
        end
        check("sat.samples",  32'(sample_count),  32'(CNT_SAT));
        check("sat.corrects", 32'(correct_count), 32'(CNT_SAT));

        // Reset mid-sample abandons it.
        for (int i = 0; i < NUM_CLASSES; i++) s_sc[i] = DATA_W'($urandom);
        drive_beats(6, -1, 3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("midrst");
        m_samples = 0;
        m_correct = 0;
        m_class   = 0;
        run_sample("post_rst", 5, 1'b0, 1'b0);
        check("post_rst.one", 32'(sample_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
